cpu_ifetch: RTL

Instruction fetch stage that sits directly upstream of the instruction cache and downstream into decode. It owns the program counter, issues one sequential fetch per cycle to the cache, tags each request with a 9-bit epoch, and discards responses made stale by a jump. Accepted instructions are buffered in a small FIFO and presented to decode with a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/cpu_ifetch_fifo.sv | 47 ++++
 rtl/cpu_ifetch.sv | 105 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the CPU front end: fetch epoch, buffered fetch entry, reset PC.
package cpu_pkg;

    typedef logic [8:0] epoch_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/cpu_ifetch_fifo.sv
// Synchronous FIFO of fetch entries with push, pop, flush and occupancy count.
// Storage is not reset; DEPTH must be a power of two so pointers wrap naturally.
module cpu_ifetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/cpu_ifetch.sv
// Instruction fetch stage: PC, epoch-tagged icache requests, stale-response filter, decode FIFO.
// Optional CPU_IFETCH_PERF_EN adds perf_fetched / perf_discarded counters.
module cpu_ifetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        cpu_icache_request,
    output logic [31:0] cpu_icache_addr,
    output logic [8:0]  cpu_icache_tag,
    input  logic        cpu_icache_ready,
    input  logic        cpu_icache_rvalid,
    input  logic [31:0] cpu_icache_rdata,
    input  logic [31:0] cpu_icache_raddr,
    input  logic [8:0]  cpu_icache_rtag,
    input  logic        jump,
    input  logic [31:0] jump_addr,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready
`ifdef CPU_IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_discarded
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]  pc;
    epoch_t       epoch;
    logic [CW-1:0] inflight;
    logic [CW-1:0] count;
    logic [CW:0]   credit_used;
    logic          handshake;
    logic          retire;
    logic          hit;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    // Credit covers both buffered entries and responses still owed, so a push always has room.
    assign credit_used        = {1'b0, inflight} + {1'b0, count};
    assign cpu_icache_request = !reset && !jump && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign cpu_icache_addr    = pc;
    assign cpu_icache_tag     = epoch;
    assign handshake          = cpu_icache_request && cpu_icache_ready;

    // Guard against underflow from responses to requests issued before a reset.
    assign retire     = cpu_icache_rvalid && (inflight != '0);
    assign hit        = cpu_icache_rvalid && (cpu_icache_rtag == epoch) && !jump;
    assign pop        = if_valid && if_ready && !jump;
    assign push_entry = '{pc: cpu_icache_raddr, instr: cpu_icache_rdata};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            epoch    <= '0;
            inflight <= '0;
        end else begin
            if (jump) begin
                pc    <= jump_addr & 32'hFFFF_FFFC;
                epoch <= epoch + 1'b1;
            end else if (handshake) begin
                pc <= pc + 32'd4;
            end
            if (handshake && !retire)      inflight <= inflight + 1'b1;
            else if (retire && !handshake) inflight <= inflight - 1'b1;
        end
    end

    cpu_ifetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (hit),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (jump),
        .head      (head),
        .count     (count)
    );

    assign if_valid = (count != '0);
    assign if_instr = if_valid ? head.instr : '0;
    assign if_pc    = if_valid ? head.pc    : '0;

`ifdef CPU_IFETCH_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetched   <= '0;
            perf_discarded <= '0;
        end else begin
            if (pop)                      perf_fetched   <= perf_fetched + 32'd1;
            if (cpu_icache_rvalid && !hit) perf_discarded <= perf_discarded + 32'd1;
        end
    end
`endif

endmodule
